// File: rtl/cache_data_ram.sv
// cache_data_ram: single-clock simple dual-port RAM for one cache way's data or tag array.
// It supports byte-strobed writes and selectable write-first or read-first collision handling.
// A hardware sweep writes INIT_VALUE into every entry after reset or on clear_req.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   clear_req  single-cycle pulse requesting a full-array clear (ignored while sweeping)
//   ready      high when the array accepts reads and writes
//   read_en    read request; read_addr selects the entry
//   read_data  registered read result, holds when no read is accepted
//   write_en   write request; write_addr selects the entry
//   write_strb per-byte write enables, bit i covers write_data[8i+7:8i]
//   write_data write data
module cache_data_ram #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 7,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter bit                    BYPASS     = 1'b1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      clear_req,
    output logic                      ready,
    input  logic                      read_en,
    input  logic [ADDR_WIDTH-1:0]     read_addr,
    output logic [DATA_WIDTH-1:0]     read_data,
    input  logic                      write_en,
    input  logic [DATA_WIDTH/8-1:0]   write_strb,
    input  logic [ADDR_WIDTH-1:0]     write_addr,
    input  logic [DATA_WIDTH-1:0]     write_data
);

    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    // One extra bit so the sweep count reaches DEPTH without wrapping.
    localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q,   state_d;
    logic [CNT_WIDTH-1:0]  counter_q, counter_d;
    logic                  ready_q,   ready_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;

    logic                  sweep_we_c;
    logic                  port_we_c;
    logic [DATA_WIDTH-1:0] fwd_word_c;

    // State, sweep counter and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_INIT;
            counter_q <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next-state, sweep control and read-data selection.
    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        ready_d    = ready_q;
        rdata_d    = rdata_q;
        sweep_we_c = 1'b0;
        port_we_c  = 1'b0;
        fwd_word_c = mem[read_addr];

        case (state_q)
            ST_INIT: begin
                sweep_we_c = 1'b1;
                counter_d  = counter_q + CNT_WIDTH'(1);
                if (counter_q == CNT_WIDTH'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    // Any port access in the clear cycle is dropped.
                    state_d   = ST_INIT;
                    counter_d = '0;
                    ready_d   = 1'b0;
                end else begin
                    port_we_c = write_en;
                    if (read_en) begin
                        // Write-first: merge strobed bytes of a same-address write into the old word.
                        for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
                            if (BYPASS && write_en && (write_addr == read_addr) && write_strb[i]) begin
                                fwd_word_c[8*i +: 8] = write_data[8*i +: 8];
                            end
                        end
                        rdata_d = fwd_word_c;
                    end
                end
            end
        endcase
    end

    // Array storage: full-word sweep writes or byte-strobed port writes.
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (sweep_we_c) begin
                mem[counter_q[ADDR_WIDTH-1:0]] <= INIT_VALUE;
            end else if (port_we_c) begin
                for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
                    if (write_strb[i]) begin
                        mem[write_addr][8*i +: 8] <= write_data[8*i +: 8];
                    end
                end
            end
        end
    end

    assign ready     = ready_q;
    assign read_data = rdata_q;

endmodule

// File: doc/cache_data_ram.md
# cache_data_ram

Parametrised single-clock simple dual-port RAM for the cache data and tag arrays, one write port and one read port. It adds byte-strobed writes, selectable write-first/read-first collision handling, and a hardware clear sweep that writes INIT_VALUE into every entry after reset or on request. Each instance holds one way's bank or tag array inside the icache/dcache, and the cache control FSMs gate their accesses on `ready`.

## Interface
Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 7: index width.
- DEPTH = 1 << ADDR_WIDTH (derived, 128 by default): number of entries.
- INIT_VALUE, 0: value written to every entry by the clear sweep.
- BYPASS, 1: same-address collision mode; 1 = write-first (forward new data), 0 = read-first (old data).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- clear_req  in  1  single-cycle pulse requesting a full-array clear.
- ready  out  1  high when the array accepts reads and writes.
- read_en  in  1  read request.
- read_addr  in  ADDR_WIDTH  read index.
- read_data  out  DATA_WIDTH  registered read result.
- write_en  in  1  write request.
- write_strb  in  DATA_WIDTH/8  byte enables; bit i covers data[8i+7:8i].
- write_addr  in  ADDR_WIDTH  write index.
- write_data  in  DATA_WIDTH  write data.

## Operation
- FSM states: INIT (clear sweep) and RUN.
- resetn low puts the block in INIT with sweep counter = 0, ready = 0, read_data = 0. These values apply immediately, without waiting for a clock edge.
- INIT: each clock edge writes INIT_VALUE to entry[counter], then increments the counter.
  - The edge that writes entry DEPTH-1 moves the FSM to RUN and sets ready = 1.
  - Port reads and writes are ignored; read_data holds its value.
  - clear_req is ignored because a sweep is already in progress.
- RUN: clear_req = 1 at an edge moves the FSM to INIT with counter = 0 and ready = 0. Any port access in that same cycle is dropped.
- Write, in RUN only: when write_en = 1, each byte whose write_strb bit is set updates entry[write_addr]; other bytes keep their value. write_strb = 0 is a no-op.
- Read, in RUN only: when read_en = 1, read_data <= entry[read_addr] at the edge. With read_en = 0, read_data holds.
- Collision: read_en, write_en and read_addr == write_addr in the same cycle.
  - BYPASS = 1: read_data = the old word with the strobed bytes replaced by write_data.
  - BYPASS = 0: read_data = the old word.
  - The array is updated in both modes.
- Different-address simultaneous read and write proceed independently.
- Contents are undefined between resetn deassertion and ready = 1. Consumers must not read before ready.

## Timing
- Read latency: 1 cycle. Address presented at edge N gives data valid after edge N, visible from cycle N+1 until the next accepted read.
- Write latency: 1 cycle. A write at edge N is visible to a read issued at edge N+1, or at edge N itself under BYPASS = 1.
- Clear duration: exactly DEPTH edges.
  - After reset: ready rises after the DEPTH-th rising edge with resetn high.
  - After clear_req: ready rises DEPTH+1 edges after the clear_req edge (1 edge into INIT, then DEPTH sweep edges).
- Reset mid-sweep or mid-access abandons the operation. The sweep restarts from entry 0 after release.
- The counter is ADDR_WIDTH+1 bits wide, so it terminates at DEPTH without wrap ambiguity. This holds when DEPTH is a power of two.
- Reset values: ready = 0, read_data = 0, state = INIT, counter = 0.

## Test plan
- Reset/sweep: release resetn, default parameters → ready stays 0 for 127 edges and is 1 after edge 128. A read of addresses 0, 64 and 127 then returns 0x00000000.
- Byte strobes: write 0xAABBCCDD to addr 5 with strb 4'b1111, then 0x11223344 with strb 4'b0101 → read addr 5 returns 0xAA22CC44 one cycle after issue.
- Collision, BYPASS = 1: entry 9 = 0x12345678; same cycle, write 0xFFFF0000 with strb 4'b1100 and read addr 9 → read_data = 0xFFFF5678. With BYPASS = 0 → 0x12345678. The next read returns 0xFFFF5678 in both modes.
- Read hold and ignore:
  - read_en low for 10 cycles → read_data unchanged.
  - Accesses while ready = 0 → no array change and read_data unchanged.
- Clear request: fill entries with nonzero data and pulse clear_req with a write in the same cycle → ready low for 129 cycles (1 + DEPTH edges), the write is dropped, and all entries read 0 afterwards. A second clear_req during INIT does not extend the sweep.
- Async reset mid-sweep: assert resetn at counter 40, off the clock edge → ready and read_data go to 0 immediately. After release, a full 128-edge sweep runs again.
